hamming_decoder: RTL and testbench

- Sequential SECDED Hamming(16,11) decoder: the inverse of the parity-generation path the ALU's RXOR_7/RXOR_8 ops serve.
- Accepts one encoded 16-bit word as two byte beats on a valid/ready stream, then returns 11 corrected data bits plus a 2-bit status as two byte beats.
- Keeps saturating error counters.
- Sits beside the datapath as a memory-mapped accelerator fed by the load/store unit.

---
 rtl/hamming_decoder_pkg.sv | 26 ++
 rtl/hamming_decoder_syndrome.sv | 53 +++++
 rtl/hamming_decoder.sv | 117 +++++++++++
 tb/tb_hamming_decoder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_decoder_pkg.sv
// Shared definitions for the SECDED Hamming(16,11) decoder.
//   dec_state_e : decoder FSM states (receive two bytes, compute, transmit two bytes)
//   ST_*        : 2-bit decode status codes
//   DATA_POS    : codeword bit position of data bits d1..d11 (index 0 = d1)
package hamming_decoder_pkg;

  typedef enum logic [2:0] {
    RX_LO = 3'd0,
    RX_HI = 3'd1,
    CALC  = 3'd2,
    TX_LO = 3'd3,
    TX_HI = 3'd4
  } dec_state_e;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_CORR = 2'b01;
  localparam logic [1:0] ST_DBL  = 2'b10;

  localparam int N_DATA = 11;

  // Non-power-of-two positions 3..15 carry data; 0,1,2,4,8 carry parity.
  localparam logic [3:0] DATA_POS [0:N_DATA-1] = '{
    4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
  };

endpackage

// File: rtl/hamming_decoder_syndrome.sv
// Combinational SECDED check of one 16-bit Hamming codeword.
//   i_word   : received codeword, bit i = position i (bit 0 = overall parity)
//   o_syn    : syndrome, XOR of indices of set bits 1..15
//   o_par    : overall parity of all 16 bits
//   o_data   : d11..d1 after correction (uncorrected on a double error)
//   o_status : ST_OK / ST_CORR / ST_DBL
module hamming_syndrome
  import hamming_decoder_pkg::*;
(
  input  logic [15:0]       i_word,
  output logic [3:0]        o_syn,
  output logic              o_par,
  output logic [N_DATA-1:0] o_data,
  output logic [1:0]        o_status
);

  logic [3:0]        w_syn;
  logic              w_par;
  logic [15:0]       w_flip;
  logic [15:0]       w_fixed;
  logic [N_DATA-1:0] w_data;
  logic [1:0]        w_status;

  always_comb begin
    w_syn = '0;
    for (int i = 1; i < 16; i++) begin
      if (i_word[i]) w_syn = w_syn ^ 4'(i);
    end

    w_par = ^i_word;

    // Odd overall parity means exactly one bit flipped; the syndrome names it,
    // with syndrome 0 pointing at the overall parity bit itself.
    w_flip = '0;
    if (w_par) w_flip[w_syn] = 1'b1;
    w_fixed = i_word ^ w_flip;

    w_data = '0;
    for (int k = 0; k < N_DATA; k++) begin
      w_data[k] = w_fixed[DATA_POS[k]];
    end

    if (w_par)              w_status = ST_CORR;
    else if (w_syn != 4'd0) w_status = ST_DBL;
    else                    w_status = ST_OK;
  end

  assign o_syn    = w_syn;
  assign o_par    = w_par;
  assign o_data   = w_data;
  assign o_status = w_status;

endmodule

// File: rtl/hamming_decoder.sv
// Sequential SECDED Hamming(16,11) decoder with byte-wide valid/ready streams.
//   clk, reset_n : clock (rising edge), asynchronous active-low reset
//   clr          : synchronous clear of FSM and error counters, beats handshakes
//   in_valid/in_ready/in_data    : encoded word in, low byte then high byte
//   out_valid/out_ready/out_data : d8..d1 first, then {status, 3'b000, d11..d9}
//   corr_cnt     : saturating count of corrected (single-error) words
//   dbl_cnt      : saturating count of double-error words
module hamming_decoder
  import hamming_decoder_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] dbl_cnt
);

  dec_state_e        r_state;
  dec_state_e        w_next;
  logic [2*W-1:0]    r_word;
  logic [N_DATA-1:0] r_data;
  logic [1:0]        r_status;
  logic [CNT_W-1:0]  r_corr_cnt;
  logic [CNT_W-1:0]  r_dbl_cnt;

  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_in_hs;
  logic              w_out_hs;
  logic [3:0]        w_syn;
  logic              w_par;
  logic [N_DATA-1:0] w_data;
  logic [1:0]        w_status;
  logic [W-1:0]      w_out_data;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  hamming_syndrome u_syndrome (
    .i_word   (r_word),
    .o_syn    (w_syn),
    .o_par    (w_par),
    .o_data   (w_data),
    .o_status (w_status)
  );

  assign w_in_ready  = (r_state == RX_LO) || (r_state == RX_HI);
  assign w_out_valid = (r_state == TX_LO) || (r_state == TX_HI);
  assign w_in_hs     = in_valid && w_in_ready;
  assign w_out_hs    = w_out_valid && out_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      RX_LO:   if (w_in_hs)  w_next = RX_HI;
      RX_HI:   if (w_in_hs)  w_next = CALC;
      CALC:                  w_next = TX_LO;
      TX_LO:   if (w_out_hs) w_next = TX_HI;
      TX_HI:   if (w_out_hs) w_next = RX_LO;
      default:               w_next = RX_LO;
    endcase
  end

  // Output mux is driven from registered result only, so it stays stable
  // while the consumer stalls.
  always_comb begin
    w_out_data = '0;
    case (r_state)
      TX_LO:   w_out_data = r_data[7:0];
      TX_HI:   w_out_data = {r_status, 3'b000, r_data[10:8]};
      default: w_out_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= RX_LO;
      r_word     <= '0;
      r_data     <= '0;
      r_status   <= ST_OK;
      r_corr_cnt <= '0;
      r_dbl_cnt  <= '0;
    end else if (clr) begin
      // Clearing in CALC drops that word's counter update along with the word.
      r_state    <= RX_LO;
      r_corr_cnt <= '0;
      r_dbl_cnt  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == RX_LO && w_in_hs) r_word[W-1:0]   <= in_data;
      if (r_state == RX_HI && w_in_hs) r_word[2*W-1:W] <= in_data;
      if (r_state == CALC) begin
        r_data   <= w_data;
        r_status <= w_status;
        if (w_status == ST_CORR) r_corr_cnt <= sat_inc(r_corr_cnt);
        if (w_status == ST_DBL)  r_dbl_cnt  <= sat_inc(r_dbl_cnt);
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = w_out_data;
  assign corr_cnt  = r_corr_cnt;
  assign dbl_cnt   = r_dbl_cnt;

endmodule

// File: tb/tb_hamming_decoder.sv
module tb_hamming_decoder;

  logic       clk;
  logic       reset_n;
  logic       clr;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [7:0] corr_cnt;
  logic [7:0] dbl_cnt;

  int errors = 0;
  int checks = 0;
  int exp_corr = 0;
  int exp_dbl = 0;

  typedef struct {
    logic [15:0] word;
    logic [7:0]  lo;
    logic [7:0]  hi;
    int          corr_inc;
    int          dbl_inc;
  } vec_t;

  vec_t vecs [10];

  hamming_decoder #(.W(8), .CNT_W(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .corr_cnt  (corr_cnt),
    .dbl_cnt   (dbl_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) timeout("send_byte");
    else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = 8'hA5;
  endtask

  task automatic recv_byte(output logic [7:0] b);
    int n;
    n = 0;
    b = 8'h00;
    out_ready = 1'b1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) timeout("recv_byte");
    else begin
      b = out_data;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic run_word(input logic [15:0] w, output logic [7:0] lo, output logic [7:0] hi);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    recv_byte(lo);
    recv_byte(hi);
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  initial begin
    logic [7:0] lo, hi;

    vecs[0] = '{16'h000F, 8'h01, 8'h00, 0, 0};  // clean, d1=1
    vecs[1] = '{16'h004F, 8'h01, 8'h40, 1, 0};  // bit 6 flipped
    vecs[2] = '{16'h000E, 8'h01, 8'h40, 1, 0};  // p0 flipped
    vecs[3] = '{16'h024F, 8'h15, 8'h80, 0, 1};  // bits 6,9 flipped
    vecs[4] = '{16'h8117, 8'h00, 8'h04, 0, 0};  // clean, d11=1
    vecs[5] = '{16'h0117, 8'h00, 8'h44, 1, 0};  // bit 15 flipped
    vecs[6] = '{16'h0006, 8'h00, 8'h80, 0, 1};  // bits 1,2 flipped
    vecs[7] = '{16'hFFFF, 8'hFF, 8'h07, 0, 0};  // clean all ones
    vecs[8] = '{16'hFFFE, 8'hFF, 8'h47, 1, 0};  // p0 flipped
    vecs[9] = '{16'h0000, 8'h00, 8'h00, 0, 0};  // clean all zeros

    reset_n   = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 16'(out_valid), 16'h0);
    chk("rst_out_data", 16'(out_data), 16'h00);
    chk("rst_corr", 16'(corr_cnt), 16'h00);
    chk("rst_dbl", 16'(dbl_cnt), 16'h00);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 16'(in_ready), 16'h1);

    for (int i = 0; i < 10; i++) begin
      run_word(vecs[i].word, lo, hi);
      exp_corr = sat(exp_corr + vecs[i].corr_inc);
      exp_dbl  = sat(exp_dbl + vecs[i].dbl_inc);
      chk($sformatf("vec%0d_lo", i), 16'(lo), 16'(vecs[i].lo));
      chk($sformatf("vec%0d_hi", i), 16'(hi), 16'(vecs[i].hi));
      chk($sformatf("vec%0d_corr", i), 16'(corr_cnt), 16'(exp_corr));
      chk($sformatf("vec%0d_dbl", i), 16'(dbl_cnt), 16'(exp_dbl));
    end

    // Backpressure and latency.
    send_byte(8'h4F);
    in_valid = 1'b1;
    in_data  = 8'h00;
    chk("bp_rx_hi_ready", 16'(in_ready), 16'h1);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 8'h3C;
    chk("bp_calc_out_valid", 16'(out_valid), 16'h0);
    chk("bp_calc_in_ready", 16'(in_ready), 16'h0);
    @(posedge clk); #1;
    chk("bp_latency_out_valid", 16'(out_valid), 16'h1);
    chk("bp_first_data", 16'(out_data), 16'h01);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_data", c), 16'(out_data), 16'h01);
      chk($sformatf("bp_hold%0d_valid", c), 16'(out_valid), 16'h1);
      chk($sformatf("bp_hold%0d_in_ready", c), 16'(in_ready), 16'h0);
    end
    in_valid = 1'b0;
    recv_byte(lo);
    recv_byte(hi);
    exp_corr = sat(exp_corr + 1);
    chk("bp_lo", 16'(lo), 16'h01);
    chk("bp_hi", 16'(hi), 16'h40);
    chk("bp_corr", 16'(corr_cnt), 16'(exp_corr));

    // Asynchronous reset while waiting for the high byte.
    send_byte(8'h0F);
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", 16'(out_valid), 16'h0);
    chk("arst_out_data", 16'(out_data), 16'h00);
    chk("arst_corr", 16'(corr_cnt), 16'h00);
    chk("arst_dbl", 16'(dbl_cnt), 16'h00);
    exp_corr = 0;
    exp_dbl  = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_in_ready", 16'(in_ready), 16'h1);
    run_word(16'h004F, lo, hi);
    exp_corr = sat(exp_corr + 1);
    chk("arst_next_lo", 16'(lo), 16'h01);
    chk("arst_next_hi", 16'(hi), 16'h40);
    chk("arst_next_corr", 16'(corr_cnt), 16'(exp_corr));

    // Drive the corrected-word counter into saturation.
    run_word(16'h0006, lo, hi);
    exp_dbl = sat(exp_dbl + 1);
    for (int k = 0; k < 256; k++) begin
      run_word(16'h000E, lo, hi);
      exp_corr = sat(exp_corr + 1);
    end
    chk("sat_corr", 16'(corr_cnt), 16'hFF);
    chk("sat_dbl", 16'(dbl_cnt), 16'(exp_dbl));
    chk("sat_last_hi", 16'(hi), 16'h40);

    // Synchronous clear.
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    exp_corr = 0;
    exp_dbl  = 0;
    chk("clr_corr", 16'(corr_cnt), 16'h00);
    chk("clr_dbl", 16'(dbl_cnt), 16'h00);

    // Clear landing in CALC discards the word and its counter update.
    run_word(16'h024F, lo, hi);
    exp_dbl = sat(exp_dbl + 1);
    chk("pre_calc_clr_dbl", 16'(dbl_cnt), 16'(exp_dbl));
    send_byte(8'h4F);
    send_byte(8'h00);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("calc_clr_corr", 16'(corr_cnt), 16'h00);
    chk("calc_clr_dbl", 16'(dbl_cnt), 16'h00);
    chk("calc_clr_out_valid", 16'(out_valid), 16'h0);
    chk("calc_clr_in_ready", 16'(in_ready), 16'h1);
    @(posedge clk); #1;
    chk("calc_clr_stays_idle", 16'(out_valid), 16'h0);
    run_word(16'h000F, lo, hi);
    chk("post_clr_lo", 16'(lo), 16'h01);
    chk("post_clr_hi", 16'(hi), 16'h00);
    chk("post_clr_corr", 16'(corr_cnt), 16'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
